// File: rtl/alu_operand_loader.sv
// ----------------------------------------------------------------------------
// alu_operand_loader
//
// Front-end stage for the ALU + result-register stage. It assembles two signed
// operands (A, B) and an ALU opcode from a little-endian byte stream with a
// valid/ready handshake. It then presents them to the ALU as one stable frame,
// marked by a one-cycle issue strobe. After the issue the frame is held for
// HOLD_CYCLES cycles so the downstream result register can capture it before
// loading resumes.
//
// Parameters
//   DATA_W       operand width, a multiple of 8 (NB = DATA_W/8 bytes per operand)
//   OP_W         opcode width, at most 8
//   HOLD_CYCLES  cycles the frame is held after issue, at least 1
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_data    in   byte stream input
//   in_valid   in   in_data is valid
//   in_ready   out  loader accepts a byte this cycle
//   flush      in   synchronous abort of a partially loaded frame
//   A, B       out  operands to the ALU; these change only when a frame issues
//   ALUOp      out  ALU operation code
//   op_valid   out  one-cycle pulse: A/B/ALUOp hold a new frame
//   op_err     out  one-cycle pulse: opcode byte rejected, frame dropped
//   frame_cnt  out  number of issued frames, wraps from 255 to 0
// ----------------------------------------------------------------------------
module alu_operand_loader #(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 3,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [OP_W-1:0]   ALUOp,
   output logic              op_valid,
   output logic              op_err,
   output logic [7:0]        frame_cnt
);

   localparam int NB     = DATA_W / 8;
   localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);
   localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      LOAD_OP,
      ISSUE,
      HOLD
   } state_t;

   state_t              state_q,     state_d;
   logic [CNT_W-1:0]    byte_cnt_q,  byte_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [DATA_W-1:0]   shadow_a_q,  shadow_a_d;
   logic [DATA_W-1:0]   shadow_b_q,  shadow_b_d;
   logic [DATA_W-1:0]   a_q,         a_d;
   logic [DATA_W-1:0]   b_q,         b_d;
   logic [OP_W-1:0]     alu_op_q,    alu_op_d;
   logic                op_valid_q,  op_valid_d;
   logic                op_err_q,    op_err_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;

   logic load_state;
   logic accept;
   logic op_ok;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      shadow_a_d  = shadow_a_q;
      shadow_b_d  = shadow_b_q;
      a_d         = a_q;
      b_d         = b_q;
      alu_op_d    = alu_op_q;
      op_valid_d  = 1'b0;
      op_err_d    = 1'b0;
      frame_cnt_d = frame_cnt_q;

      load_state = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
      // Gated with rst so the source sees no ready while reset is held.
      in_ready   = load_state & ~rst;
      accept     = in_valid & in_ready;
      // The opcode is legal only if every bit above OP_W is zero. This also covers OP_W == 8.
      op_ok      = ((in_data >> OP_W) == 8'd0);

      if (load_state && flush) begin
         // flush takes priority over a byte accepted in the same cycle; that byte is dropped.
         state_d    = LOAD_A;
         byte_cnt_d = '0;
         shadow_a_d = '0;
         shadow_b_d = '0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (accept) begin
                  for (int k = 0; k < NB; k++) begin
                     if (byte_cnt_q == CNT_W'(k)) shadow_a_d[8*k +: 8] = in_data;
                  end
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     state_d    = LOAD_B;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end

            LOAD_B: begin
               if (accept) begin
                  for (int k = 0; k < NB; k++) begin
                     if (byte_cnt_q == CNT_W'(k)) shadow_b_d[8*k +: 8] = in_data;
                  end
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     state_d    = LOAD_OP;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end

            LOAD_OP: begin
               if (accept) begin
                  if (op_ok) begin
                     // The opcode goes straight to ALUOp on the edge that enters ISSUE,
                     // so it needs no separate shadow flop.
                     a_d        = shadow_a_q;
                     b_d        = shadow_b_q;
                     alu_op_d   = in_data[OP_W-1:0];
                     op_valid_d = 1'b1;
                     state_d    = ISSUE;
                  end else begin
                     op_err_d   = 1'b1;
                     shadow_a_d = '0;
                     shadow_b_d = '0;
                     state_d    = LOAD_A;
                  end
               end
            end

            ISSUE: begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               hold_cnt_d  = '0;
               state_d     = HOLD;
            end

            HOLD: begin
               if (hold_cnt_q == LAST_HOLD) begin
                  hold_cnt_d = '0;
                  state_d    = LOAD_A;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            default: state_d = LOAD_A;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the shadow registers are reset as well, so no partial frame survives a reset.
         state_q     <= LOAD_A;
         byte_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         shadow_a_q  <= '0;
         shadow_b_q  <= '0;
         a_q         <= '0;
         b_q         <= '0;
         alu_op_q    <= '0;
         op_valid_q  <= 1'b0;
         op_err_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         shadow_a_q  <= shadow_a_d;
         shadow_b_q  <= shadow_b_d;
         a_q         <= a_d;
         b_q         <= b_d;
         alu_op_q    <= alu_op_d;
         op_valid_q  <= op_valid_d;
         op_err_q    <= op_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign ALUOp     = alu_op_q;
   assign op_valid  = op_valid_q;
   assign op_err    = op_err_q;
   assign frame_cnt = frame_cnt_q;

endmodule
